// File: rtl/alu_op_issue.sv
// alu_op_issue
// Producer end of the 4-bit ALU operation interface. The block decodes the main-control
// ALU class plus funct3/funct7[5] into an ALU opcode, a branch-polarity flag and an
// illegal flag. It hands each decoded entry to EX over a valid/ready handshake, backed
// by a head register and a skid register.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset (clears valids and data)
//   flush       discards every buffered entry (valids only)
//   id_valid    ID offers an entry this cycle
//   id_ready    block can take an entry (registered: !skid_valid)
//   alu_class   00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic
//   funct3      instruction funct3
//   funct7_5    instruction bit 30
//   ex_ready    EX accepts the head entry
//   ex_valid    head entry valid
//   ex_aluop    ALU opcode of the head entry
//   ex_br_inv   branch taken when (zero ^ ex_br_inv)
//   ex_illegal  head entry has an illegal encoding
module alu_op_issue #(
    parameter bit ADD_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       id_valid,
    output logic       id_ready,
    input  logic [1:0] alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       ex_ready,
    output logic       ex_valid,
    output logic [3:0] ex_aluop,
    output logic       ex_br_inv,
    output logic       ex_illegal
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_ILLEGAL = ADD_ON_ILLEGAL ? OP_ADD : OP_AND;

    typedef struct packed {
        logic [3:0] aluop;
        logic       br_inv;
        logic       illegal;
    } entry_t;

    logic [3:0] dec_op;
    logic       dec_inv;
    logic       dec_ill;
    entry_t     dec_entry;

    entry_t head_reg;
    entry_t skid_reg;
    logic   head_valid_reg;
    logic   skid_valid_reg;

    logic accept;
    logic issue;

    always_comb begin
        dec_op  = OP_ADD;
        dec_inv = 1'b0;
        dec_ill = 1'b0;
        case (alu_class)
            2'b00: dec_op = OP_ADD;
            2'b01: begin
                // Branches compare with sub/slt/sltu; br_inv selects the polarity
                // of the zero flag that means "taken".
                case (funct3)
                    3'b000:  dec_op = OP_SUB;
                    3'b001: begin
                        dec_op  = OP_SUB;
                        dec_inv = 1'b1;
                    end
                    3'b100: begin
                        dec_op  = OP_SLT;
                        dec_inv = 1'b1;
                    end
                    3'b101:  dec_op = OP_SLT;
                    3'b110: begin
                        dec_op  = OP_SLTU;
                        dec_inv = 1'b1;
                    end
                    3'b111:  dec_op = OP_SLTU;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: begin
                // R-type (10) and I-type (11) share the funct3 map. In I-type,
                // bit 30 is an immediate bit except for the shift encodings.
                case (funct3)
                    3'b000:  dec_op = (funct7_5 && !alu_class[0]) ? OP_SUB : OP_ADD;
                    3'b001:  dec_op = OP_SLL;
                    3'b010:  dec_op = OP_SLT;
                    3'b011:  dec_op = OP_SLTU;
                    3'b100:  dec_op = OP_XOR;
                    3'b101:  dec_op = funct7_5 ? OP_SRA : OP_SRL;
                    3'b110:  dec_op = OP_OR;
                    default: dec_op = OP_AND;
                endcase
                if (funct7_5) begin
                    if (!alu_class[0]) begin
                        dec_ill = (funct3 != 3'b000) && (funct3 != 3'b101);
                    end else begin
                        dec_ill = (funct3 == 3'b001);
                    end
                end
            end
        endcase
        if (dec_ill) begin
            dec_op  = OP_ILLEGAL;
            dec_inv = 1'b0;
        end
    end

    assign dec_entry = '{aluop: dec_op, br_inv: dec_inv, illegal: dec_ill};

    assign accept = id_valid && !skid_valid_reg;
    assign issue  = head_valid_reg && ex_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg       <= '0;
            skid_reg       <= '0;
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (flush) begin
            head_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (!head_valid_reg || issue) begin
            // Head is free this edge: the older skid entry goes first. id_ready is
            // low while skid is occupied, so no accept can collide with it.
            if (skid_valid_reg) begin
                head_reg       <= skid_reg;
                head_valid_reg <= 1'b1;
            end else begin
                head_valid_reg <= accept;
                if (accept) begin
                    head_reg <= dec_entry;
                end
            end
            skid_valid_reg <= 1'b0;
        end else if (accept) begin
            // Head stalled: park the new entry so ID does not need to hold it.
            skid_reg       <= dec_entry;
            skid_valid_reg <= 1'b1;
        end
    end

    assign id_ready   = !skid_valid_reg;
    assign ex_valid   = head_valid_reg;
    assign ex_aluop   = head_reg.aluop;
    assign ex_br_inv  = head_reg.br_inv;
    assign ex_illegal = head_reg.illegal;
endmodule
